// File: rtl/relin_tile_collector.sv
// Adds relin output tiles to the latched c0/c1 ciphertext mod Q and queues the results for a valid/ready sink.
// Latency 2 cycles valid_i->valid_o; never stalls upstream (overflow drops); RELIN_COLLECT_RANGE_CHECK_EN adds operand range checks.
module relin_tile_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         push_drop,
    input  logic         pop_rdy,
    output logic         head_vld,
    output logic [W-1:0] head_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]             cnt_q, cnt_d;
    logic                    full, pop, wr;

    assign full      = (cnt_q == (AW+1)'(DEPTH));
    assign head_vld  = (cnt_q != '0);
    assign pop       = head_vld & pop_rdy;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr        = push_vld & (~full | pop);
    assign push_drop = push_vld & full & ~pop;
    assign head_dat  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module relin_tile_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE_N     = 4,
    parameter int DEGREE_N   = 16,
    parameter int MODULUS    = 97,
    parameter int FIFO_DEPTH = 4,
    localparam int NUM_TILES = DEGREE_N / TILE_N,
    localparam int IDX_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic [DEGREE_N*DATA_WIDTH-1:0] c0_i,
    input  logic [DEGREE_N*DATA_WIDTH-1:0] c1_i,
    input  logic                           valid_i,
    input  logic [TILE_N*DATA_WIDTH-1:0]   c0_coeff_i,
    input  logic [TILE_N*DATA_WIDTH-1:0]   c1_coeff_i,
    output logic                           busy_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [TILE_N*DATA_WIDTH-1:0]   c0_o,
    output logic [TILE_N*DATA_WIDTH-1:0]   c1_o,
    output logic [IDX_W-1:0]               tile_idx_o,
    output logic                           last_o,
    output logic                           done_o,
    output logic [2:0]                     err_o
);
    localparam logic [DATA_WIDTH:0] MOD_EXT  = (DATA_WIDTH+1)'(MODULUS);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_TILES - 1);

    typedef logic [TILE_N-1:0][DATA_WIDTH-1:0] tile_dat_t;
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;
    typedef struct packed {
        logic             last;
        logic [IDX_W-1:0] idx;
        tile_dat_t        c1;
        tile_dat_t        c0;
    } tile_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               tile_cnt_q, tile_cnt_d;
    logic [NUM_TILES-1:0][TILE_N-1:0][DATA_WIDTH-1:0] c0_lat_q, c0_lat_d, c1_lat_q, c1_lat_d;
    logic                           stg_vld_q, stg_vld_d;
    tile_t                          stg_q, stg_d;
    logic                           done_q, done_d;
    logic [2:0]                     err_q, err_d;

    tile_dat_t c0_coeff_t, c1_coeff_t, c0_tile, c1_tile, sum0, sum1;
    tile_t     head;
    logic      head_vld, push_drop, pop, accept, range_err;

    assign c0_coeff_t = c0_coeff_i;
    assign c1_coeff_t = c1_coeff_i;
    assign c0_tile    = c0_lat_q[tile_cnt_q];
    assign c1_tile    = c1_lat_q[tile_cnt_q];
    assign accept     = (state_q == S_COLLECT) & valid_i;

    // Operands are below Q, so one conditional subtract fully reduces the sum.
    for (genvar gi = 0; gi < TILE_N; gi++) begin : g_add
        logic [DATA_WIDTH:0] s0, s1;
        assign s0 = {1'b0, c0_coeff_t[gi]} + {1'b0, c0_tile[gi]};
        assign s1 = {1'b0, c1_coeff_t[gi]} + {1'b0, c1_tile[gi]};
        assign sum0[gi] = (s0 >= MOD_EXT) ? DATA_WIDTH'(s0 - MOD_EXT) : s0[DATA_WIDTH-1:0];
        assign sum1[gi] = (s1 >= MOD_EXT) ? DATA_WIDTH'(s1 - MOD_EXT) : s1[DATA_WIDTH-1:0];
    end

`ifdef RELIN_COLLECT_RANGE_CHECK_EN
    logic [TILE_N-1:0] ovr;
    for (genvar gi = 0; gi < TILE_N; gi++) begin : g_rng
        assign ovr[gi] = ({1'b0, c0_coeff_t[gi]} >= MOD_EXT) | ({1'b0, c1_coeff_t[gi]} >= MOD_EXT) |
                         ({1'b0, c0_tile[gi]} >= MOD_EXT)    | ({1'b0, c1_tile[gi]} >= MOD_EXT);
    end
    assign range_err = accept & (|ovr);
`else
    assign range_err = 1'b0;
`endif

    relin_tile_fifo #(
        .W     ($bits(tile_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (stg_vld_q),
        .push_dat  (stg_q),
        .push_drop (push_drop),
        .pop_rdy   (ready_i),
        .head_vld  (head_vld),
        .head_dat  (head)
    );

    assign pop = head_vld & ready_i;

    always_comb begin
        state_d    = state_q;
        tile_cnt_d = tile_cnt_q;
        c0_lat_d   = c0_lat_q;
        c1_lat_d   = c1_lat_q;
        stg_vld_d  = accept;
        stg_d      = stg_q;
        done_d     = 1'b0;
        err_d      = err_q | {range_err, valid_i & (state_q != S_COLLECT), push_drop};
        if (accept) begin
            stg_d.c0   = sum0;
            stg_d.c1   = sum1;
            stg_d.idx  = tile_cnt_q;
            stg_d.last = (tile_cnt_q == LAST_IDX);
        end
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    c0_lat_d   = c0_i;
                    c1_lat_d   = c1_i;
                    tile_cnt_d = '0;
                    state_d    = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // Dropped tiles still advance the counter so tile framing is preserved.
                if (valid_i) begin
                    if (tile_cnt_q == LAST_IDX) begin
                        tile_cnt_d = '0;
                        state_d    = S_DRAIN;
                    end else begin
                        tile_cnt_d = tile_cnt_q + IDX_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (pop && head.last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tile_cnt_q <= '0;
            stg_vld_q  <= 1'b0;
            stg_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            tile_cnt_q <= tile_cnt_d;
            stg_vld_q  <= stg_vld_d;
            stg_q      <= stg_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        c0_lat_q <= c0_lat_d;
        c1_lat_q <= c1_lat_d;
    end

    // Outputs are forced to zero while empty so stale FIFO contents never show.
    assign busy_o     = (state_q != S_IDLE);
    assign valid_o    = head_vld;
    assign c0_o       = head_vld ? head.c0 : '0;
    assign c1_o       = head_vld ? head.c1 : '0;
    assign tile_idx_o = head_vld ? head.idx : '0;
    assign last_o     = head_vld & head.last;
    assign done_o     = done_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_relin_tile_collector.sv
// Randomized bench for relin_tile_collector: scoreboard of expected tiles computed as (c + coeff) mod Q.
module tb_relin_tile_collector;
    localparam int DW = 8, TN = 4, DN = 16, Q = 97, NT = 4;

    logic           clk = 1'b0;
    logic           rst, start_i, valid_i, ready_i, ready2;
    logic [DN*DW-1:0] c0_i, c1_i;
    logic [TN*DW-1:0] c0_coeff_i, c1_coeff_i;
    logic           busy_o, valid_o, last_o, done_o;
    logic [TN*DW-1:0] c0_o, c1_o;
    logic [1:0]     tile_idx_o;
    logic [2:0]     err_o;
    logic           busy2, valid2, last2, done2;
    logic [TN*DW-1:0] c0_2, c1_2;
    logic [1:0]     idx2;
    logic [2:0]     err2;

    always #5 clk = ~clk;

    relin_tile_collector #(.DATA_WIDTH(DW), .TILE_N(TN), .DEGREE_N(DN), .MODULUS(Q), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .c0_i(c0_i), .c1_i(c1_i), .valid_i(valid_i),
        .c0_coeff_i(c0_coeff_i), .c1_coeff_i(c1_coeff_i), .busy_o(busy_o), .valid_o(valid_o),
        .ready_i(ready_i), .c0_o(c0_o), .c1_o(c1_o), .tile_idx_o(tile_idx_o), .last_o(last_o),
        .done_o(done_o), .err_o(err_o));

    relin_tile_collector #(.DATA_WIDTH(DW), .TILE_N(TN), .DEGREE_N(DN), .MODULUS(Q), .FIFO_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start_i(start_i), .c0_i(c0_i), .c1_i(c1_i), .valid_i(valid_i),
        .c0_coeff_i(c0_coeff_i), .c1_coeff_i(c1_coeff_i), .busy_o(busy2), .valid_o(valid2),
        .ready_i(ready2), .c0_o(c0_2), .c1_o(c1_2), .tile_idx_o(idx2), .last_o(last2),
        .done_o(done2), .err_o(err2));

    int n_tests = 0, n_fail = 0;
    int m_c0[DN], m_c1[DN], m_k0[DN], m_k1[DN];
    logic [66:0] exp_q[$];
    bit   mon_en = 0, done_pend = 0, rdy_rand = 0, rdy_force = 1;
    int   done_cnt = 0;
    logic [2:0] err_exp = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready_i = rdy_rand ? ($urandom_range(3) != 0) : rdy_force;
        end
    end

    always @(negedge clk) begin
        bit hs_last;
        if (mon_en) begin
            check("done", done_o, done_pend);
            if (done_o) done_cnt++;
            hs_last = 0;
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tile", valid_o, 1'b0);
                end else begin
                    check("tile", {last_o, tile_idx_o, c1_o, c0_o}, exp_q[0]);
                    if (ready_i) begin
                        hs_last = exp_q[0][66];
                        void'(exp_q.pop_front());
                    end
                end
            end
            done_pend = hs_last;
        end
    end

    task automatic do_reset();
        mon_en    = 0;
        rst       = 1;
        start_i   = 0;
        valid_i   = 0;
        repeat (2) tick();
        rst       = 0;
        exp_q.delete();
        done_pend = 0;
        err_exp   = '0;
        @(negedge clk);
        check("rst_ctl", {busy_o, valid_o, last_o, done_o, err_o, tile_idx_o}, '0);
        check("rst_dat", {c1_o, c0_o}, '0);
        check("rst_ctl2", {busy2, valid2, last2, done2, err2, idx2}, '0);
        mon_en = 1;
    endtask

    task automatic clear_model();
        for (int j = 0; j < DN; j++) begin
            m_c0[j] = 0; m_c1[j] = 0; m_k0[j] = 0; m_k1[j] = 0;
        end
    endtask

    task automatic rand_model();
        for (int j = 0; j < DN; j++) begin
            m_c0[j] = $urandom_range(Q-1); m_c1[j] = $urandom_range(Q-1);
            m_k0[j] = $urandom_range(Q-1); m_k1[j] = $urandom_range(Q-1);
        end
    endtask

    task automatic send_ct(input bit chk_lat, input bit gaps);
        logic [66:0] e;
        logic [DW-1:0] b;
        for (int k = 0; k < NT; k++) begin
            e = '0;
            for (int i = 0; i < TN; i++) begin
                b = DW'((m_c0[k*TN+i] + m_k0[k*TN+i]) % Q);
                e[i*DW +: DW] = b;
                b = DW'((m_c1[k*TN+i] + m_k1[k*TN+i]) % Q);
                e[32 + i*DW +: DW] = b;
            end
            e[65:64] = 2'(k);
            e[66]    = (k == NT-1);
            exp_q.push_back(e);
        end
        for (int j = 0; j < DN; j++) begin
            c0_i[j*DW +: DW] = DW'(m_c0[j]);
            c1_i[j*DW +: DW] = DW'(m_c1[j]);
        end
        start_i = 1;
        tick();
        start_i = 0;
        c0_i = {4{$urandom()}};
        c1_i = {4{$urandom()}};
        @(negedge clk);
        check("busy", busy_o, 1'b1);
        for (int k = 0; k < NT; k++) begin
            if (gaps) begin
                repeat ($urandom_range(2)) begin
                    valid_i = 0;
                    tick();
                end
            end
            valid_i = 1;
            for (int i = 0; i < TN; i++) begin
                c0_coeff_i[i*DW +: DW] = DW'(m_k0[k*TN+i]);
                c1_coeff_i[i*DW +: DW] = DW'(m_k1[k*TN+i]);
            end
            // start_i while collecting must be ignored
            if (gaps && $urandom_range(3) == 0) start_i = 1;
            if (chk_lat && k == 1) begin
                @(negedge clk);
                check("lat_early", valid_o, 1'b0);
            end
            if (chk_lat && k == 2) begin
                @(negedge clk);
                check("lat_two", valid_o, 1'b1);
            end
            tick();
            start_i = 0;
        end
        valid_i = 0;
    endtask

    task automatic wait_done();
        int start_cnt = done_cnt;
        int n = 0;
        while (done_cnt == start_cnt && n < 300) begin
            tick();
            n++;
        end
        check("done_seen", done_cnt, start_cnt + 1);
        tick();
        check("busy_end", busy_o, 1'b0);
    endtask

    initial begin
        ready_i = 1; ready2 = 1;
        c0_i = '0; c1_i = '0; c0_coeff_i = '0; c1_coeff_i = '0;
        do_reset();

        clear_model();
        send_ct(0, 0);
        wait_done();

        for (int j = 0; j < DN; j++) begin
            m_c0[j] = j; m_c1[j] = 2*j; m_k0[j] = 10; m_k1[j] = 10;
        end
        send_ct(1, 0);
        wait_done();
        check("err_basic", err_o, err_exp);

        clear_model();
        m_c0[0] = 96; m_k0[0] = 96;
        send_ct(0, 0);
        wait_done();
        m_c0[0] = 1;
        send_ct(0, 0);
        wait_done();

        rdy_force = 0;
        rand_model();
        tick();
        send_ct(0, 0);
        repeat (4) tick();
        @(negedge clk);
        check("bp_valid", valid_o, 1'b1);
        check("bp_err", err_o, err_exp);
        rdy_force = 1;
        wait_done();

        rdy_rand = 1;
        for (int t = 0; t < 20; t++) begin
            rand_model();
            send_ct(0, 1);
            wait_done();
        end
        rdy_rand = 0;
        check("err_rand", err_o, err_exp);

        ready2 = 0;
        do_reset();
        rand_model();
        send_ct(0, 0);
        wait_done();
        check("ovf_err2", err2, 3'b001);
        check("ovf_head2", {valid2, idx2}, 3'b100);
        check("ovf_err1", err_o, err_exp);

`ifdef RELIN_COLLECT_RANGE_CHECK_EN
        rand_model();
        m_k1[2] = 97;
        send_ct(0, 0);
        wait_done();
        err_exp[2] = 1'b1;
        check("range_err", err_o, err_exp);
`endif

        valid_i = 1;
        tick();
        valid_i = 0;
        err_exp[1] = 1'b1;
        @(negedge clk);
        check("stray_err", err_o, err_exp);
        check("stray_err2", err2, 3'b011);
        repeat (3) tick();
        check("stray_noout", valid_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
